// File: rtl/tank_sensor_bank.sv
// tank_sensor_bank: CHANNELS sensor readings of WIDTH bits. One registered
// display channel either auto-scans the readings or holds a manually chosen
// one. Out-of-range writes set sticky per-channel alarms, and any alarm
// forces the all-ones error pattern onto the display.
//
// Optional build macro: TANK_ERR_AUTOCLR_EN. When it is defined, an in-range
// write to a channel clears that channel's alarm bit.
//
// Handshake: none. wr_en is a single-cycle strobe with no back-pressure. A
// write is accepted at the rising edge when wr_en=1 and wr_chan<CHANNELS.
//
// The display registers load from the state the FSM enters at the same edge.
// They use the readings as they were before that edge. A mode or man_sel
// change is therefore visible after one edge. A write to the shown channel
// shows the old value for one cycle, then the new one.
module tank_sensor_bank #(
    parameter int              WIDTH    = 8,
    parameter int              CHANNELS = 4,
    parameter int              CHAN_W   = 2,
    parameter int              DWELL    = 4,
    parameter logic [WIDTH-1:0] LO_LIMIT = 8'h04,
    parameter logic [WIDTH-1:0] HI_LIMIT = 8'hF0
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [CHAN_W-1:0]   wr_chan,
    input  logic [WIDTH-1:0]    wr_data,
    input  logic                mode,
    input  logic [CHAN_W-1:0]   man_sel,
    input  logic                err_clr,
    output logic [WIDTH-1:0]    disp_data,
    output logic [CHAN_W-1:0]   disp_chan,
    output logic                disp_valid,
    output logic                err_flag,
    output logic [CHANNELS-1:0] err_chan_mask,
    output logic [1:0]          fsm_state
);

    localparam int                DW_W       = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CHAN_W:0]   CH_LIMIT   = (CHAN_W + 1)'(CHANNELS);
    localparam logic [CHAN_W-1:0] CHAN_LAST  = CHAN_W'(CHANNELS - 1);
    localparam logic [DW_W-1:0]   DWELL_LAST = DW_W'(DWELL - 1);

    typedef enum logic [1:0] {
        ST_SCAN  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_ERROR = 2'd2
    } state_t;

    state_t              state;
    logic [WIDTH-1:0]    readings [CHANNELS];
    logic [CHANNELS-1:0] written;
    logic [CHAN_W-1:0]   scan_chan;
    logic [DW_W-1:0]     dwell_cnt;

    logic                wr_ok;
    logic                wr_out_of_range;
    logic [CHANNELS-1:0] mask_next;
    logic [CHAN_W-1:0]   err_low_chan;
    logic [CHAN_W-1:0]   scan_next_chan;
    logic [DW_W-1:0]     scan_next_dwell;
    logic [WIDTH-1:0]    scan_data;
    logic                scan_valid;
    logic [WIDTH-1:0]    hold_data;
    logic                hold_valid;

    assign fsm_state = state;

    // A write to a channel that does not exist is dropped entirely.
    assign wr_ok           = wr_en && ({1'b0, wr_chan} < CH_LIMIT);
    assign wr_out_of_range = (wr_data < LO_LIMIT) || (wr_data > HI_LIMIT);

    // Next alarm mask: clear-all first, then the per-channel write effect,
    // so that a coincident out-of-range write wins over err_clr.
    always_comb begin
        mask_next = err_chan_mask;
        if (err_clr) begin
            mask_next = '0;
        end
        for (int i = 0; i < CHANNELS; i++) begin
            if (wr_ok && (wr_chan == CHAN_W'(i))) begin
                if (wr_out_of_range) begin
                    mask_next[i] = 1'b1;
                end
`ifdef TANK_ERR_AUTOCLR_EN
                else begin
                    mask_next[i] = 1'b0;
                end
`endif
            end
        end
    end

    // Lowest-index alarmed channel, shown as disp_chan while in ERROR.
    always_comb begin
        err_low_chan = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (err_chan_mask[i]) begin
                err_low_chan = CHAN_W'(i);
            end
        end
    end

    // Scan position after this edge. Arriving from another state restarts
    // at channel 0. Otherwise the dwell counter steps and wraps the channel.
    always_comb begin
        scan_next_chan  = scan_chan;
        scan_next_dwell = dwell_cnt;
        if (state != ST_SCAN) begin
            scan_next_chan  = '0;
            scan_next_dwell = '0;
        end else if (dwell_cnt == DWELL_LAST) begin
            scan_next_dwell = '0;
            scan_next_chan  = (scan_chan == CHAN_LAST) ? '0 : scan_chan + 1'b1;
        end else begin
            scan_next_dwell = dwell_cnt + 1'b1;
        end
    end

    // Reading and written flag for the scan channel and the manual channel.
    // A manual index beyond CHANNELS matches nothing and reads as zero/invalid.
    always_comb begin
        scan_data  = '0;
        scan_valid = 1'b0;
        hold_data  = '0;
        hold_valid = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (scan_next_chan == CHAN_W'(i)) begin
                scan_data  = readings[i];
                scan_valid = written[i];
            end
            if (man_sel == CHAN_W'(i)) begin
                hold_data  = readings[i];
                hold_valid = written[i];
            end
        end
    end

    // Reading storage and the written-since-reset mask.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                readings[i] <= '0;
            end
            written <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (wr_ok && (wr_chan == CHAN_W'(i))) begin
                    readings[i] <= wr_data;
                    written[i]  <= 1'b1;
                end
            end
        end
    end

    // Sticky alarm bits; err_flag trails the mask by one cycle.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            err_chan_mask <= '0;
            err_flag      <= 1'b0;
        end else begin
            err_chan_mask <= mask_next;
            err_flag      <= |err_chan_mask;
        end
    end

    // Display FSM with priority ERROR > HOLD > SCAN. The display registers
    // load from the state being entered at this edge.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state      <= ST_SCAN;
            scan_chan  <= '0;
            dwell_cnt  <= '0;
            disp_data  <= '0;
            disp_chan  <= '0;
            disp_valid <= 1'b0;
        end else if (err_flag) begin
            state      <= ST_ERROR;
            disp_data  <= '1;
            disp_chan  <= err_low_chan;
            disp_valid <= 1'b1;
        end else if (mode) begin
            state      <= ST_HOLD;
            disp_data  <= hold_data;
            disp_chan  <= man_sel;
            disp_valid <= hold_valid;
        end else begin
            state      <= ST_SCAN;
            scan_chan  <= scan_next_chan;
            dwell_cnt  <= scan_next_dwell;
            disp_data  <= scan_data;
            disp_chan  <= scan_next_chan;
            disp_valid <= scan_valid;
        end
    end

endmodule

// File: tb/tb_tank_sensor_bank.sv
// Directed bench for tank_sensor_bank (CHANNELS=4, CHAN_W=3, DWELL=4).
// It covers scanning, manual hold, alarm set/clear, ignored writes and
// asynchronous reset. Build with TANK_ERR_AUTOCLR_EN to cover auto-clear.
module tb_tank_sensor_bank;

    localparam int WIDTH    = 8;
    localparam int CHANNELS = 4;
    localparam int CHAN_W   = 3;
    localparam int DWELL    = 4;

    localparam logic [31:0] ST_SCAN  = 32'd0;
    localparam logic [31:0] ST_HOLD  = 32'd1;
    localparam logic [31:0] ST_ERROR = 32'd2;

    logic                CLK     = 1'b0;
    logic                reset   = 1'b1;
    logic                wr_en   = 1'b0;
    logic [CHAN_W-1:0]   wr_chan = '0;
    logic [WIDTH-1:0]    wr_data = '0;
    logic                mode    = 1'b0;
    logic [CHAN_W-1:0]   man_sel = '0;
    logic                err_clr = 1'b0;
    logic [WIDTH-1:0]    disp_data;
    logic [CHAN_W-1:0]   disp_chan;
    logic                disp_valid;
    logic                err_flag;
    logic [CHANNELS-1:0] err_chan_mask;
    logic [1:0]          fsm_state;

    int total  = 0;
    int passed = 0;

    logic [7:0]        scan_exp_data [4] = '{8'h1C, 8'h38, 8'h70, 8'h0E};
    logic [CHAN_W-1:0] scan_exp_chan [4] = '{3'd1, 3'd2, 3'd3, 3'd0};

    tank_sensor_bank #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .CHAN_W   (CHAN_W),
        .DWELL    (DWELL),
        .LO_LIMIT (8'h04),
        .HI_LIMIT (8'hF0)
    ) dut (
        .CLK           (CLK),
        .reset         (reset),
        .wr_en         (wr_en),
        .wr_chan       (wr_chan),
        .wr_data       (wr_data),
        .mode          (mode),
        .man_sel       (man_sel),
        .err_clr       (err_clr),
        .disp_data     (disp_data),
        .disp_chan     (disp_chan),
        .disp_valid    (disp_valid),
        .err_flag      (err_flag),
        .err_chan_mask (err_chan_mask),
        .fsm_state     (fsm_state)
    );

    // Clock
    always #5 CLK = ~CLK;

    // Advance one rising edge and settle 1 ns past it.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // One-cycle write strobe.
    task automatic write_ch(input logic [CHAN_W-1:0] ch, input logic [WIDTH-1:0] d);
        wr_en   = 1'b1;
        wr_chan = ch;
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        // Reset state; the outputs are cleared with no edge needed.
        #1;
        chk("rst_disp_data", 32'(disp_data), 32'h0);
        chk("rst_disp_valid", 32'(disp_valid), 32'h0);
        chk("rst_mask", 32'(err_chan_mask), 32'h0);
        chk("rst_state", 32'(fsm_state), ST_SCAN);
        step();
        step();
        reset = 1'b0;

        // Writes while scanning. On the ch0 write edge, ch0 shows as not yet written.
        write_ch(3'd0, 8'h0E);
        chk("wr0_old_data", 32'(disp_data), 32'h0);
        chk("wr0_old_valid", 32'(disp_valid), 32'h0);
        write_ch(3'd1, 8'h1C);
        chk("wr1_ch0_data", 32'(disp_data), 32'h0E);
        chk("wr1_ch0_valid", 32'(disp_valid), 32'h1);
        write_ch(3'd2, 8'h38);
        write_ch(3'd3, 8'h70);

        // Scan sequence: ch1..ch3 then wrap to ch0, DWELL cycles each.
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("scan_data_%0d", k), 32'(disp_data), 32'(scan_exp_data[k / DWELL]));
            chk($sformatf("scan_chan_%0d", k), 32'(disp_chan), 32'(scan_exp_chan[k / DWELL]));
            chk($sformatf("scan_valid_%0d", k), 32'(disp_valid), 32'h1);
            step();
        end

        // Manual hold on ch2.
        mode    = 1'b1;
        man_sel = 3'd2;
        step();
        chk("hold_data", 32'(disp_data), 32'h38);
        chk("hold_chan", 32'(disp_chan), 32'h2);
        chk("hold_state", 32'(fsm_state), ST_HOLD);
        step();
        chk("hold_steady", 32'(disp_data), 32'h38);
        write_ch(3'd2, 8'h40);
        chk("hold_wr_old", 32'(disp_data), 32'h38);
        step();
        chk("hold_wr_new", 32'(disp_data), 32'h40);

        // High out-of-range write on ch3 raises the alarm.
        write_ch(3'd3, 8'hF5);
        chk("hi_mask", 32'(err_chan_mask), 32'h8);
        chk("hi_flag_lag", 32'(err_flag), 32'h0);
        step();
        chk("hi_flag", 32'(err_flag), 32'h1);
        chk("hi_disp_prev", 32'(disp_data), 32'h40);
        step();
        chk("err_data", 32'(disp_data), 32'hFF);
        chk("err_chan", 32'(disp_chan), 32'h3);
        chk("err_valid", 32'(disp_valid), 32'h1);
        chk("err_state", 32'(fsm_state), ST_ERROR);

        // Clear the alarm and return to scanning.
        mode    = 1'b0;
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("clr_mask", 32'(err_chan_mask), 32'h0);
        chk("clr_flag_lag", 32'(err_flag), 32'h1);
        step();
        chk("clr_flag", 32'(err_flag), 32'h0);
        chk("clr_still_err", 32'(disp_data), 32'hFF);
        step();
        chk("resume_state", 32'(fsm_state), ST_SCAN);
        chk("resume_data", 32'(disp_data), 32'h0E);
        chk("resume_chan", 32'(disp_chan), 32'h0);

        // Low alarm on ch0, then err_clr together with a low write on ch1.
        write_ch(3'd0, 8'h01);
        chk("lo_mask", 32'(err_chan_mask), 32'h1);
        step();
        chk("lo_flag", 32'(err_flag), 32'h1);
        err_clr = 1'b1;
        write_ch(3'd1, 8'h02);
        err_clr = 1'b0;
        chk("set_wins_mask", 32'(err_chan_mask), 32'h2);
        chk("set_wins_flag", 32'(err_flag), 32'h1);
        step();
        chk("set_wins_flag2", 32'(err_flag), 32'h1);
        chk("err_low_chan", 32'(disp_chan), 32'h1);

        // Clear and move to HOLD with a man_sel beyond the channel count.
        mode    = 1'b1;
        man_sel = 3'd6;
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        step();
        step();
        chk("bad_sel_data", 32'(disp_data), 32'h0);
        chk("bad_sel_chan", 32'(disp_chan), 32'h6);
        chk("bad_sel_valid", 32'(disp_valid), 32'h0);

        // A write to a channel that does not exist has no effect.
        write_ch(3'd5, 8'hF9);
        chk("ign_mask", 32'(err_chan_mask), 32'h0);
        step();
        chk("ign_flag", 32'(err_flag), 32'h0);
        man_sel = 3'd1;
        step();
        chk("ign_ch1_data", 32'(disp_data), 32'h02);
        chk("ign_ch1_valid", 32'(disp_valid), 32'h1);

        // Assert reset while in ERROR; the outputs clear before the next edge.
        write_ch(3'd3, 8'hF5);
        step();
        step();
        chk("pre_rst_state", 32'(fsm_state), ST_ERROR);
        #2;
        reset = 1'b1;
        #1;
        chk("async_data", 32'(disp_data), 32'h0);
        chk("async_valid", 32'(disp_valid), 32'h0);
        chk("async_flag", 32'(err_flag), 32'h0);
        chk("async_mask", 32'(err_chan_mask), 32'h0);
        chk("async_state", 32'(fsm_state), ST_SCAN);
        step();
        step();
        mode  = 1'b0;
        reset = 1'b0;
        step();
        chk("post_rst_state", 32'(fsm_state), ST_SCAN);
        chk("post_rst_chan", 32'(disp_chan), 32'h0);
        chk("post_rst_valid", 32'(disp_valid), 32'h0);
        chk("post_rst_data", 32'(disp_data), 32'h0);

        // An in-range write clears the alarm bit only when auto-clear is built in.
        write_ch(3'd3, 8'hF5);
        chk("ac_set", 32'(err_chan_mask), 32'h8);
        write_ch(3'd3, 8'h20);
`ifdef TANK_ERR_AUTOCLR_EN
        chk("ac_clear", 32'(err_chan_mask), 32'h0);
`else
        chk("ac_sticky", 32'(err_chan_mask), 32'h8);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/tank_sensor_bank.md
Name: tank_sensor_bank

Overview:
Parametrised successor to the fixed four-register tank-status store and one-hot display mux. It holds CHANNELS sensor readings (cleanliness, temperature, food storage, saltiness, and further channels as needed) of WIDTH bits each. It drives one registered display channel that either auto-scans the readings or holds a manually selected one. It applies sticky out-of-range alarms, and while any alarm is set it forces the all-ones error pattern onto the display.

Parameters:
WIDTH, 8, bits per sensor reading
CHANNELS, 4, number of sensor channels (2..16)
CHAN_W, 2, channel index width; must satisfy 2**CHAN_W >= CHANNELS
DWELL, 4, cycles each channel is shown in auto-scan (>=1)
LO_LIMIT, 8'h04, reading strictly below this raises the channel alarm
HI_LIMIT, 8'hF0, reading strictly above this raises the channel alarm

Ports:
CLK  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high; clears all state
wr_en  in  1  write strobe for a sensor reading
wr_chan  in  CHAN_W  target channel of the write
wr_data  in  WIDTH  reading value
mode  in  1  0 = auto-scan, 1 = manual hold
man_sel  in  CHAN_W  channel displayed in manual mode
err_clr  in  1  clears all alarm bits
disp_data  out  WIDTH  registered display value
disp_chan  out  CHAN_W  channel currently shown
disp_valid  out  1  shown channel has been written since reset
err_flag  out  1  OR of err_chan_mask
err_chan_mask  out  CHANNELS  sticky per-channel alarm bits

Behaviour:
- Reset (asynchronous): clears all readings, the written mask, err_chan_mask, err_flag, disp_data, disp_chan, disp_valid and the dwell counter. The FSM goes to SCAN at channel 0.
- Write: when wr_en=1 and wr_chan<CHANNELS, the reading is stored at the edge and that channel's written bit is set. Writes with wr_chan>=CHANNELS are ignored and have no side effects.
- Alarm:
  - On an accepted write with wr_data<LO_LIMIT or wr_data>HI_LIMIT, err_chan_mask[wr_chan] is set at the same edge.
  - err_flag is registered and equals the OR of the mask one cycle later.
  - err_clr=1 clears the whole mask. If err_clr and an out-of-range write occur in the same cycle, the set wins for that channel.
  - Readings are checked only on write. Reset zeros never raise an alarm.
- FSM states SCAN, HOLD, ERROR. State is evaluated each edge, priority ERROR > HOLD > SCAN:
  - Any state -> ERROR when err_flag=1.
  - ERROR -> SCAN or HOLD (per mode) the edge after err_flag falls.
  - SCAN <-> HOLD follows mode.
  - Entering SCAN from any other state restarts at channel 0 with the dwell counter at 0.
- SCAN:
  - The dwell counter counts 0..DWELL-1. On DWELL-1 the channel advances, wrapping from CHANNELS-1 to 0.
  - Each channel is displayed for exactly DWELL cycles.
- HOLD: the shown channel is man_sel. If man_sel>=CHANNELS, disp_data=0, disp_chan=man_sel and disp_valid=0.
- ERROR:
  - disp_data is all ones.
  - disp_chan is the lowest-index set bit of err_chan_mask.
  - disp_valid=1.
- Latency:
  - disp_data, disp_chan and disp_valid are registered from the current state and readings.
  - A write at edge N to the displayed channel appears on disp_data after edge N+1.
  - A channel change is visible one edge after the selection changes.
- Simultaneous write and display of the same channel: the display shows the old value for one cycle, then the new one.
- Reset asserted mid-scan or mid-error: all outputs go to reset values immediately, without waiting for a clock edge.

Optional Feature:
TANK_ERR_AUTOCLR_EN
- Defined: an accepted in-range write (LO_LIMIT<=wr_data<=HI_LIMIT) to a channel clears that channel's alarm bit at the same edge. err_clr still clears all bits. If err_clr coincides with an out-of-range write, the set still wins.
- Undefined: alarm bits clear only via err_clr or reset.

Test Plan:
- Reset, then write ch0=0x0E, ch1=0x1C, ch2=0x38, ch3=0x70 in mode=0 -> disp_data cycles 0x0E,0x1C,0x38,0x70, each for 4 cycles, then wraps to 0x0E; disp_valid=1 throughout.
- mode=1, man_sel=2 -> after 1 edge disp_data=0x38, disp_chan=2, held steady. Write ch2=0x40 -> disp_data=0x40 after the second edge.
- Write ch3=0xF5 -> err_chan_mask=4'b1000 at that edge; err_flag=1 one cycle later; then disp_data=0xFF and disp_chan=3. Pulse err_clr -> the cycle after err_flag falls, SCAN resumes at ch0 with disp_data=0x0E.
- Same cycle: err_clr=1 and write ch1=0x02 -> err_chan_mask=4'b0010; err_flag remains 1.
- Write wr_chan=5 with CHAN_W=3, CHANNELS=4 -> no reading or mask change. man_sel=6 in HOLD -> disp_data=0, disp_valid=0.
- Assert reset during ERROR -> all outputs 0 immediately. After release, SCAN ch0 with disp_valid=0. With TANK_ERR_AUTOCLR_EN, write ch3=0xF5 then ch3=0x20 -> mask bit 3 clears without err_clr.
